key_debounce: RTL

Input conditioner for the four active-low push-buttons that the mole game reads as hit inputs. It synchronizes `KEY[3:0]` into the `CLOCK_50` domain and runs an independent debounce state machine on each key. It emits one-cycle, active-high press and release pulses plus a clean held level. The game logic consumes only these outputs, never raw `KEY`, so one physical press produces exactly one hit event.

---
 rtl/key_debounce_if.sv | 20 ++
 rtl/key_debounce.sv | 130 +++++++++++++
 2 files changed

// File: rtl/key_debounce_if.sv
// Bundle of the raw button inputs and the conditioned outputs of key_debounce.
// The slave side is the debouncer; the master side is whoever drives KEY and consumes events.
interface key_debounce_if;
  logic [3:0] KEY;
  logic [3:0] press;
  logic [3:0] release_p;
  logic [3:0] held;
  logic       press_any;
  logic [1:0] press_idx;

  modport master (
    output KEY,
    input  press, release_p, held, press_any, press_idx
  );

  modport slave (
    input  KEY,
    output press, release_p, held, press_any, press_idx
  );
endinterface

// File: rtl/key_debounce.sv
// Four-key push-button conditioner: two-flop synchronizer, then an independent debounce
// FSM per key producing one-cycle press/release pulses and a clean held level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24
) (
  input  logic           CLOCK_50,
  input  logic           RESET_N,
  key_debounce_if.slave  bus
);

  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, REL_PEND} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       s1;
  logic [3:0]       s;
  state_t           state [4];
  logic [CNT_W-1:0] cnt   [4];

  logic [3:0] press_hit;
  logic [3:0] release_hit;

  logic [3:0] press_q;
  logic [3:0] release_q;
  logic [3:0] held_q;
  logic       press_any_q;
  logic [1:0] press_idx_q;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_idx = 2'(i);
    end
  endfunction

  // Acceptance conditions, shared by the FSM and the registered pulse outputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    press_hit   = '0;
    release_hit = '0;
    for (int i = 0; i < 4; i++) begin
      press_hit[i]   = (state[i] == PRESS_PEND) &&  s[i] && (cnt[i] == CNT_LAST);
      release_hit[i] = (state[i] == REL_PEND)   && !s[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      s1          <= '0;
      s           <= '0;
      press_q     <= '0;
      release_q   <= '0;
      held_q      <= '0;
      press_any_q <= 1'b0;
      press_idx_q <= 2'd0;
      // NOTE: the per-key counters are plain flops, not a RAM, so clearing them in reset is free and required.
      for (int i = 0; i < 4; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make s1 -> s a true two-stage shift regardless of statement order.
      s1          <= ~bus.KEY;
      s           <= s1;
      press_q     <= press_hit;
      release_q   <= release_hit;
      press_any_q <= |press_hit;
      press_idx_q <= lowest_idx(press_hit);

      for (int i = 0; i < 4; i++) begin
        case (state[i])
          RELEASED: begin
            if (s[i]) begin
              state[i] <= PRESS_PEND;
              cnt[i]   <= CNT_ONE;
            end else begin
              cnt[i]   <= '0;
            end
          end
          PRESS_PEND: begin
            if (!s[i]) begin
              state[i]  <= RELEASED;
              cnt[i]    <= '0;
            end else if (press_hit[i]) begin
              state[i]  <= PRESSED;
              held_q[i] <= 1'b1;
              cnt[i]    <= '0;
            end else begin
              cnt[i]    <= cnt[i] + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!s[i]) begin
              state[i] <= REL_PEND;
              cnt[i]   <= CNT_ONE;
            end else begin
              cnt[i]   <= '0;
            end
          end
          REL_PEND: begin
            if (s[i]) begin
              state[i]  <= PRESSED;
              cnt[i]    <= '0;
            end else if (release_hit[i]) begin
              state[i]  <= RELEASED;
              held_q[i] <= 1'b0;
              cnt[i]    <= '0;
            end else begin
              cnt[i]    <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            state[i]  <= RELEASED;
            held_q[i] <= 1'b0;
            cnt[i]    <= '0;
          end
        endcase
      end
    end
  end

  assign bus.press     = press_q;
  assign bus.release_p = release_q;
  assign bus.held      = held_q;
  assign bus.press_any = press_any_q;
  assign bus.press_idx = press_idx_q;

endmodule
